fp_add_ctrl: RTL and testbench
==============================

FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, res.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 res  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  requester presents an operand pair to the adder datapath.
REQ-005 in_ready  output  1  controller accepts an operation; high only in IDLE.
REQ-006 round_carry  input  1  rounding stage mantissa carry-out (bit 24 after +1), sampled in ROUND.
REQ-007 exp_ovf  input  1  exponent increment overflow (bit 8 of incremented exponent), sampled in NORM and RENORM.
REQ-008 sum_zero  input  1  adder mantissa result is zero, sampled in ADD.
REQ-009 en_align, en_add, en_norm, en_round, en_renorm  output  1 each  one-hot datapath stage enables.
REQ-010 out_valid  output  1  result in datapath output register is final.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 overflow  output  1  per-operation sticky exponent overflow, valid while out_valid.
REQ-013 round_err  output  1  a second rounding carry occurred on one operation, valid while out_valid.

Function
REQ-014 States: IDLE, ALIGN, ADD, NORM, ROUND, RENORM, DONE; exactly one stage enable is high in the like-named state, none in IDLE/DONE.
REQ-015 IDLE -> ALIGN when in_valid && in_ready; otherwise stay.
REQ-016 ALIGN -> ADD unconditionally after 1 cycle.
REQ-017 ADD -> DONE if sum_zero, else -> NORM.
REQ-018 NORM -> ROUND unconditionally.
REQ-019 ROUND: round_carry=0 -> DONE; round_carry=1 and first pass -> RENORM; round_carry=1 on second pass -> DONE with round_err=1.
REQ-020 RENORM -> ROUND unconditionally; a 1-bit pass flag SHALL cap rounding at two passes.
REQ-021 Latency from accept edge to out_valid: 5 cycles nominal, 7 with one renormalization, 3 when sum_zero.
REQ-022 DONE holds out_valid, overflow, round_err stable until out_ready=1; then -> IDLE next cycle.
REQ-023 in_ready SHALL be 0 in DONE even if out_ready=1; minimum one IDLE bubble between operations.
REQ-024 overflow SHALL be set when exp_ovf=1 in NORM or RENORM and SHALL never clear within an operation.
REQ-025 overflow, round_err and the pass flag SHALL clear on the accept edge.
REQ-026 exp_ovf and round_carry SHALL be ignored outside their sampling states.

Reset
REQ-027 res=1 at any clock edge, including mid-operation, SHALL force IDLE, all enables 0, out_valid=0, overflow=0, round_err=0, pass flag=0; in_ready=1 from the first cycle after res deasserts.
REQ-028 An operation in flight at reset SHALL be discarded with no out_valid.

Configuration
REQ-029 Macro FP_ADD_CTRL_PERF_EN: when defined, outputs op_count[15:0] (increments on each out_valid && out_ready) and renorm_count[15:0] (increments on each RENORM entry) SHALL exist, both wrapping at 16'hFFFF -> 0 and cleared by res.
REQ-030 Without FP_ADD_CTRL_PERF_EN those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-031 Package fp_add_pkg SHALL hold the state enum, EXP_W=8, FRA_W=23, and latency constants LAT_NOM=5, LAT_RENORM=7, LAT_ZERO=3.
REQ-032 The counters SHALL be one sub-module, fp_add_perf_cnt, instantiated only under FP_ADD_CTRL_PERF_EN.

Verification
REQ-033 Accept at cycle 0, round_carry=0, sum_zero=0 -> enables ALIGN,ADD,NORM,ROUND on cycles 1-4, out_valid at cycle 5, overflow=0.
REQ-034 round_carry=1 on first ROUND, exp_ovf=1 in RENORM -> out_valid at cycle 7, overflow=1, round_err=0.
REQ-035 sum_zero=1 in ADD -> out_valid at cycle 3, en_norm/en_round never asserted.
REQ-036 round_carry=1 on both ROUND passes -> out_valid at cycle 7 with round_err=1; next accept clears round_err.
REQ-037 out_ready held 0 for 10 cycles in DONE, then 1 -> outputs stable throughout, IDLE next cycle, in_ready=1.
REQ-038 res=1 during ADD -> next cycle IDLE, enables 0, no out_valid; with FP_ADD_CTRL_PERF_EN op_count=0.

Source files
------------

// File: rtl/fp_add_pkg.sv
// ---------------------------------------------------------------------------
// fp_add_pkg
// Shared definitions for the floating-point adder controller.
//   - state_t      : controller state encoding (one state per datapath stage)
//   - stage_en_t   : bundle of the one-hot datapath stage enables
//   - EXP_W/FRA_W  : single-precision exponent and fraction widths
//   - LAT_*        : accept-to-out_valid latencies in cycles
//   - stage_enables: maps a state onto its stage enable bundle
// Optional feature macro used by the files importing this package:
//   FP_ADD_CTRL_PERF_EN (adds the performance counters to fp_add_ctrl)
// ---------------------------------------------------------------------------
package fp_add_pkg;

    localparam int EXP_W      = 8;
    localparam int FRA_W      = 23;

    localparam int LAT_NOM    = 5;
    localparam int LAT_RENORM = 7;
    localparam int LAT_ZERO   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADD    = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        RENORM = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic align;
        logic add;
        logic norm;
        logic round;
        logic renorm;
    } stage_en_t;

    // Each working state drives exactly its own stage enable; IDLE and DONE
    // leave the datapath untouched so the output register holds its result.
    function automatic stage_en_t stage_enables(input state_t s);
        stage_en_t e;
        e = '0;
        case (s)
            ALIGN:   e.align  = 1'b1;
            ADD:     e.add    = 1'b1;
            NORM:    e.norm   = 1'b1;
            ROUND:   e.round  = 1'b1;
            RENORM:  e.renorm = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/fp_add_perf_cnt.sv
// ---------------------------------------------------------------------------
// fp_add_perf_cnt
// Performance counters for the adder controller. Only instantiated when
// FP_ADD_CTRL_PERF_EN is defined.
// Ports:
//   clk           rising-edge clock
//   res           synchronous active-high reset, clears both counters
//   op_done       one-cycle strobe per completed hand-off (out_valid&&out_ready)
//   renorm_entry  one-cycle strobe on each entry into RENORM
//   op_count      completed operations, wraps 16'hFFFF -> 0
//   renorm_count  renormalization passes, wraps 16'hFFFF -> 0
// ---------------------------------------------------------------------------
module fp_add_perf_cnt (
    input  logic        clk,
    input  logic        res,
    input  logic        op_done,
    input  logic        renorm_entry,
    output logic [15:0] op_count,
    output logic [15:0] renorm_count
);

    // Completed-operation counter; natural 16-bit overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (res) begin
            op_count <= 16'd0;
        end else if (op_done) begin
            op_count <= op_count + 16'd1;
        end
    end

    // Renormalization counter, bumped once per RENORM entry.
    always_ff @(posedge clk) begin
        if (res) begin
            renorm_count <= 16'd0;
        end else if (renorm_entry) begin
            renorm_count <= renorm_count + 16'd1;
        end
    end

endmodule

// File: rtl/fp_add_ctrl.sv
// ---------------------------------------------------------------------------
// fp_add_ctrl
// Sequencing controller for a single-precision floating-point adder datapath.
// Walks one operation through ALIGN, ADD, NORM, ROUND (and at most one
// RENORM/ROUND retry), then presents the result until the consumer takes it.
// Ports:
//   clk, res                   clock, synchronous active-high reset
//   in_valid / in_ready        operand hand-off (in_ready only in IDLE)
//   round_carry                rounding carry-out, looked at in ROUND only
//   exp_ovf                    exponent increment overflow, NORM/RENORM only
//   sum_zero                   zero mantissa sum, looked at in ADD only
//   en_align..en_renorm        one-hot datapath stage enables
//   out_valid / out_ready      result hand-off
//   overflow                   sticky exponent overflow for this operation
//   round_err                  rounding carried on both passes
//   op_count, renorm_count     only with FP_ADD_CTRL_PERF_EN defined
// Optional feature macro: FP_ADD_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module fp_add_ctrl
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        round_carry,
    input  logic        exp_ovf,
    input  logic        sum_zero,
    output logic        en_align,
    output logic        en_add,
    output logic        en_norm,
    output logic        en_round,
    output logic        en_renorm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        round_err
`ifdef FP_ADD_CTRL_PERF_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] renorm_count
`endif
);

    state_t    state;
    state_t    state_next;
    stage_en_t stage_en;
    logic      accept;
    logic      pass_flag;
    logic      overflow_r;
    logic      round_err_r;

    assign accept = in_valid && in_ready;

    // Next-state logic. The pass flag distinguishes the first rounding pass
    // from the retry after RENORM, which caps rounding at two passes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                state_next = ADD;
            end
            ADD: begin
                if (sum_zero) begin
                    state_next = DONE;
                end else begin
                    state_next = NORM;
                end
            end
            NORM: begin
                state_next = ROUND;
            end
            ROUND: begin
                if (round_carry && !pass_flag) begin
                    state_next = RENORM;
                end else begin
                    state_next = DONE;
                end
            end
            RENORM: begin
                state_next = ROUND;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset drops any in-flight operation straight to IDLE,
    // so no result is ever presented for it.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Per-operation status. Everything clears when a new operation is taken;
    // otherwise overflow only ever sets, and a carry on the retry pass is
    // recorded as a rounding error instead of starting a third pass.
    always_ff @(posedge clk) begin
        if (res) begin
            pass_flag   <= 1'b0;
            overflow_r  <= 1'b0;
            round_err_r <= 1'b0;
        end else if (accept) begin
            pass_flag   <= 1'b0;
            overflow_r  <= 1'b0;
            round_err_r <= 1'b0;
        end else begin
            if ((state == NORM || state == RENORM) && exp_ovf) begin
                overflow_r <= 1'b1;
            end
            if (state == ROUND && round_carry) begin
                if (!pass_flag) begin
                    pass_flag <= 1'b1;
                end else begin
                    round_err_r <= 1'b1;
                end
            end
        end
    end

    // Moore outputs decoded purely from the current state, so they are
    // glitch-free and stay stable for the whole of DONE.
    always_comb begin
        stage_en  = stage_enables(state);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        en_align  = stage_en.align;
        en_add    = stage_en.add;
        en_norm   = stage_en.norm;
        en_round  = stage_en.round;
        en_renorm = stage_en.renorm;
        overflow  = overflow_r;
        round_err = round_err_r;
    end

`ifdef FP_ADD_CTRL_PERF_EN
    logic op_done;
    logic renorm_entry;

    // RENORM is only reachable from ROUND, so a ROUND->RENORM transition
    // marks each entry exactly once.
    always_comb begin
        op_done      = out_valid && out_ready;
        renorm_entry = (state == ROUND) && (state_next == RENORM);
    end

    fp_add_perf_cnt u_perf (
        .clk          (clk),
        .res          (res),
        .op_done      (op_done),
        .renorm_entry (renorm_entry),
        .op_count     (op_count),
        .renorm_count (renorm_count)
    );
`endif

endmodule

// File: tb/tb_fp_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_add_ctrl
// Directed self-checking bench for fp_add_ctrl. Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point.
// Works with or without FP_ADD_CTRL_PERF_EN defined.
// ---------------------------------------------------------------------------
module tb_fp_add_ctrl;

    logic clk;
    logic res;
    logic in_valid;
    logic in_ready;
    logic round_carry;
    logic exp_ovf;
    logic sum_zero;
    logic en_align;
    logic en_add;
    logic en_norm;
    logic en_round;
    logic en_renorm;
    logic out_valid;
    logic out_ready;
    logic overflow;
    logic round_err;
`ifdef FP_ADD_CTRL_PERF_EN
    logic [15:0] op_count;
    logic [15:0] renorm_count;
`endif

    int checks;
    int failures;

    fp_add_ctrl dut (
        .clk          (clk),
        .res          (res),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .round_carry  (round_carry),
        .exp_ovf      (exp_ovf),
        .sum_zero     (sum_zero),
        .en_align     (en_align),
        .en_add       (en_add),
        .en_norm      (en_norm),
        .en_round     (en_round),
        .en_renorm    (en_renorm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .round_err    (round_err)
`ifdef FP_ADD_CTRL_PERF_EN
        ,
        .op_count     (op_count),
        .renorm_count (renorm_count)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected {align,add,norm,round,renorm} in cycle c after the accept
    // cycle, for an operation whose result appears in cycle lat.
    function automatic logic [4:0] expEn(input int lat, input int c);
        logic [4:0] e;
        e = 5'b00000;
        case (c)
            1: e = 5'b10000;
            2: e = 5'b01000;
            3: e = (lat == 3) ? 5'b00000 : 5'b00100;
            4: e = (lat == 3) ? 5'b00000 : 5'b00010;
            5: e = (lat == 7) ? 5'b00001 : 5'b00000;
            6: e = (lat == 7) ? 5'b00010 : 5'b00000;
            default: e = 5'b00000;
        endcase
        return e;
    endfunction

    // Runs one operation. Bit k of zv/cv/ov is the value of sum_zero,
    // round_carry and exp_ovf driven during cycle k (cycle 0 = accept cycle).
    // Checks the enable sequence, out_valid timing and final status flags.
    task automatic applyStimulus(input string tag, input logic [7:0] zv,
                                 input logic [7:0] cv, input logic [7:0] ov,
                                 input int lat, input logic expOvf,
                                 input logic expRerr);
        checkOutput({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        in_valid    = 1'b1;
        sum_zero    = zv[0];
        round_carry = cv[0];
        exp_ovf     = ov[0];
        for (int c = 1; c <= lat; c++) begin
            stepCycle();
            in_valid    = 1'b0;
            sum_zero    = zv[c];
            round_carry = cv[c];
            exp_ovf     = ov[c];
            checkOutput($sformatf("%s_en_c%0d", tag, c),
                        {11'd0, en_align, en_add, en_norm, en_round, en_renorm},
                        {11'd0, expEn(lat, c)});
            checkOutput($sformatf("%s_out_valid_c%0d", tag, c),
                        {15'd0, out_valid}, {15'd0, (c == lat)});
        end
        checkOutput({tag, "_overflow"},  {15'd0, overflow},  {15'd0, expOvf});
        checkOutput({tag, "_round_err"}, {15'd0, round_err}, {15'd0, expRerr});
        checkOutput({tag, "_in_ready_done"}, {15'd0, in_ready}, 16'd0);
    endtask

    // Holds the result for 'hold' cycles with out_ready low, then hands it
    // off and checks the return to IDLE.
    task automatic finishOp(input string tag, input int hold,
                            input logic expOvf, input logic expRerr);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            stepCycle();
            checkOutput($sformatf("%s_hold_valid_%0d", tag, i),
                        {15'd0, out_valid}, 16'd1);
            checkOutput($sformatf("%s_hold_flags_%0d", tag, i),
                        {14'd0, overflow, round_err}, {14'd0, expOvf, expRerr});
        end
        out_ready   = 1'b1;
        sum_zero    = 1'b0;
        round_carry = 1'b0;
        exp_ovf     = 1'b0;
        #1;
        checkOutput({tag, "_in_ready_ordy"}, {15'd0, in_ready}, 16'd0);
        stepCycle();
        out_ready = 1'b0;
        checkOutput({tag, "_idle_in_ready"},  {15'd0, in_ready},  16'd1);
        checkOutput({tag, "_idle_out_valid"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        res         = 1'b1;
        in_valid    = 1'b0;
        round_carry = 1'b0;
        exp_ovf     = 1'b0;
        sum_zero    = 1'b0;
        out_ready   = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("rst_en", {11'd0, en_align, en_add, en_norm, en_round, en_renorm}, 16'd0);
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_flags", {14'd0, overflow, round_err}, 16'd0);
        res = 1'b0;
        #1;
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
`ifdef FP_ADD_CTRL_PERF_EN
        checkOutput("rst_op_count", op_count, 16'd0);
        checkOutput("rst_renorm_count", renorm_count, 16'd0);
`endif

        // Nominal path; carries and overflows outside their sampling states.
        applyStimulus("nom", 8'b0000_0000, 8'b0010_1110, 8'b0011_0111, 5, 1'b0, 1'b0);
        finishOp("nom", 0, 1'b0, 1'b0);

        // One renormalization with exponent overflow during RENORM.
        applyStimulus("renorm", 8'b0000_0000, 8'b0001_0000, 8'b0010_0000, 7, 1'b1, 1'b0);
        finishOp("renorm", 0, 1'b1, 1'b0);

        // Zero sum short-cuts straight to DONE.
        applyStimulus("zero", 8'b0000_0100, 8'b0000_0000, 8'b0000_0000, 3, 1'b0, 1'b0);
        finishOp("zero", 0, 1'b0, 1'b0);

        // Carry on both rounding passes plus overflow in NORM; long hold.
        applyStimulus("dblrnd", 8'b0000_0000, 8'b0101_0000, 8'b0000_1000, 7, 1'b1, 1'b1);
        finishOp("dblrnd", 10, 1'b1, 1'b1);

        // Next operation must start with clean status flags.
        applyStimulus("clear", 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 5, 1'b0, 1'b0);
        finishOp("clear", 0, 1'b0, 1'b0);

`ifdef FP_ADD_CTRL_PERF_EN
        checkOutput("perf_op_count", op_count, 16'd5);
        checkOutput("perf_renorm_count", renorm_count, 16'd2);
`endif

        // Reset while in ADD discards the operation.
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        exp_ovf  = 1'b1;
        stepCycle();
        checkOutput("midrst_in_add", {15'd0, en_add}, 16'd1);
        res = 1'b1;
        stepCycle();
        res     = 1'b0;
        exp_ovf = 1'b0;
        checkOutput("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("midrst_en", {11'd0, en_align, en_add, en_norm, en_round, en_renorm}, 16'd0);
        checkOutput("midrst_flags", {14'd0, overflow, round_err}, 16'd0);
`ifdef FP_ADD_CTRL_PERF_EN
        checkOutput("midrst_op_count", op_count, 16'd0);
        checkOutput("midrst_renorm_count", renorm_count, 16'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            checkOutput($sformatf("midrst_no_valid_%0d", i), {15'd0, out_valid}, 16'd0);
        end

        // Controller recovers normally after the reset.
        applyStimulus("post", 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 5, 1'b0, 1'b0);
        finishOp("post", 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
